// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sram_port_arbiter: round-robin sharing of one 2R1W SRAM among NREQ clients, |
// | fixed two-cycle read latency with write-to-read bypass.  Rev 1.0            |
// +-----------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   wr_valid,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]   wr_ready,
  input  logic [NREQ-1:0]   rd_valid,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]   rd_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic              WE,
  output logic [AW-1:0]     WriteAddress,
  output logic [DW-1:0]     WriteBus,
  output logic [AW-1:0]     ReadAddress1,
  output logic [AW-1:0]     ReadAddress2,
  input  logic [DW-1:0]     ReadBus1,
  input  logic [DW-1:0]     ReadBus2
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW-1:0]   wr_idx;
  logic            wr_any;
  logic [PW-1:0]   rd1_idx;
  logic [PW-1:0]   rd2_idx;
  logic            rd1_any;
  logic            rd2_any;
  logic            we_q;
  logic            p1_vld;
  logic            p2_vld;
  logic [PW-1:0]   p1_tag;
  logic [PW-1:0]   p2_tag;
  logic [DW-1:0]   rd_data1;
  logic [DW-1:0]   rd_data2;
  logic [NREQ-1:0] hit1;
  logic [NREQ-1:0] hit2;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Grants are suppressed while reset is held so no handshake is silently lost.
  always_comb begin : wr_scan
    logic [PW-1:0] idx;
    idx    = '0;
    wr_idx = '0;
    wr_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_add(wp, k);
      if (!wr_any && wr_valid[idx]) begin
        wr_any = 1'b1;
        wr_idx = idx;
      end
    end
    if (reset) wr_any = 1'b0;
  end

  always_comb begin : rd_scan
    logic [PW-1:0] idx;
    idx     = '0;
    rd1_idx = '0;
    rd2_idx = '0;
    rd1_any = 1'b0;
    rd2_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_add(rp, k);
      if (rd_valid[idx]) begin
        if (!rd1_any) begin
          rd1_any = 1'b1;
          rd1_idx = idx;
        end else if (!rd2_any) begin
          rd2_any = 1'b1;
          rd2_idx = idx;
        end
      end
    end
    if (reset) begin
      rd1_any = 1'b0;
      rd2_any = 1'b0;
    end
  end

  always_comb begin
    wr_ready = '0;
    rd_ready = '0;
    if (wr_any)  wr_ready[wr_idx]  = 1'b1;
    if (rd1_any) rd_ready[rd1_idx] = 1'b1;
    if (rd2_any) rd_ready[rd2_idx] = 1'b1;
  end

  // Stage A: capture granted requests toward the memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      we_q         <= 1'b0;
      WriteAddress <= '0;
      WriteBus     <= '0;
      ReadAddress1 <= '0;
      ReadAddress2 <= '0;
      p1_vld       <= 1'b0;
      p2_vld       <= 1'b0;
      p1_tag       <= '0;
      p2_tag       <= '0;
    end else begin
      we_q   <= wr_any;
      p1_vld <= rd1_any;
      p2_vld <= rd2_any;
      if (wr_any) begin
        wp           <= wrap_add(wr_idx, 1);
        WriteAddress <= wr_addr[wr_idx*AW +: AW];
        WriteBus     <= wr_data[wr_idx*DW +: DW];
      end
      if (rd1_any) begin
        p1_tag       <= rd1_idx;
        ReadAddress1 <= rd_addr[rd1_idx*AW +: AW];
        rp           <= wrap_add(rd2_any ? rd2_idx : rd1_idx, 1);
      end
      if (rd2_any) begin
        p2_tag       <= rd2_idx;
        ReadAddress2 <= rd_addr[rd2_idx*AW +: AW];
      end
    end
  end

  // A write registered before a reset must never reach the array.
  assign WE = we_q & ~reset;

  // Stage B: the write in flight this cycle has not landed yet, so forward it.
  assign rd_data1 = (we_q && (WriteAddress == ReadAddress1)) ? WriteBus : ReadBus1;
  assign rd_data2 = (we_q && (WriteAddress == ReadAddress2)) ? WriteBus : ReadBus2;

  for (genvar i = 0; i < NREQ; i++) begin : g_hit
    assign hit1[i] = p1_vld && (p1_tag == PW'(i));
    assign hit2[i] = p2_vld && (p2_tag == PW'(i));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= hit1 | hit2;
      for (int i = 0; i < NREQ; i++) begin
        if (hit1[i])      rsp_data[i*DW +: DW] <= rd_data1;
        else if (hit2[i]) rsp_data[i*DW +: DW] <= rd_data2;
      end
    end
  end

endmodule
`default_nettype wire
